// File: rtl/spd_i2c_pkg.sv
// Shared types for the SPD I2C arbiter.
//   arb_state_e    : arbiter FSM states
//   i2c_cmd_t      : one byte-level command handed to the I2C master
//   SPD_SLAVE_ADDR : base 7-bit address of the DIMM SPD EEPROM
package spd_i2c_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    HOLD     = 2'd3
  } arb_state_e;

  // "reg" is a keyword, so the register/byte offset field is reg_ofs.
  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] reg_ofs;
    logic [7:0] wdata;
  } i2c_cmd_t;

  localparam logic [6:0] SPD_SLAVE_ADDR = 7'h50;

endpackage

// File: rtl/spd_i2c_arbiter_rr_picker.sv
// rr_picker: round-robin one-hot select.
//   valid_i  : N_REQ request vector
//   ptr_i    : index with highest priority this round
//   onehot_o : one-hot winner (0 when no valid)
//   idx_o    : binary index of winner (0 when no valid)
module rr_picker #(
  parameter int N_REQ = 2,
  parameter int PW    = 1
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [PW-1:0]    idx_o
);

  // Scan from the lowest priority up so the last hit (closest to ptr_i) wins.
  always_comb begin
    int j;
    j        = 0;
    onehot_o = '0;
    idx_o    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % N_REQ;
      if (valid_i[j]) begin
        onehot_o    = '0;
        onehot_o[j] = 1'b1;
        idx_o       = PW'(j);
      end
    end
  end

endmodule

// File: rtl/spd_i2c_arbiter.sv
// spd_i2c_arbiter: shares one byte-level I2C master between N_REQ requesters.
// Round-robin per transaction, optional bus lock for back-to-back transfers
// (bounded by LOCK_MAX), and a response timeout against hung slaves.
//   i_req_*  / o_req_ready : requester command side (valid/ready)
//   o_rsp_*                : response pulse to the granted requester
//   o_cmd_* / i_cmd_ready  : registered command to the I2C master
//   i_rsp_*                : master response strobe
//   o_grant                : one-hot current owner
//   o_bus_error            : pulse on timeout or stray master response
module spd_i2c_arbiter
  import spd_i2c_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 200_000,
  parameter int LOCK_MAX       = 64
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_REQ-1:0]   i_req_valid,
  output logic [N_REQ-1:0]   o_req_ready,
  input  logic [N_REQ-1:0]   i_req_lock,
  input  logic [N_REQ-1:0]   i_req_rw,
  input  logic [7*N_REQ-1:0] i_req_addr,
  input  logic [8*N_REQ-1:0] i_req_reg,
  input  logic [8*N_REQ-1:0] i_req_wdata,
  output logic [N_REQ-1:0]   o_rsp_valid,
  output logic [7:0]         o_rsp_rdata,
  output logic               o_rsp_nack,
  output logic               o_rsp_timeout,
  output logic               o_cmd_valid,
  input  logic               i_cmd_ready,
  output logic               o_cmd_rw,
  output logic [6:0]         o_cmd_addr,
  output logic [7:0]         o_cmd_reg,
  output logic [7:0]         o_cmd_wdata,
  input  logic               i_rsp_valid,
  input  logic [7:0]         i_rsp_rdata,
  input  logic               i_rsp_nack,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_bus_error
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_MAX - 1);
  localparam logic [PW-1:0] IDX_LAST   = PW'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]    gidx_q, gidx_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [TW-1:0]    timer_q, timer_d;
  i2c_cmd_t         cmd_q, cmd_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic             rsp_nack_q, rsp_nack_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             bus_err_q, bus_err_d;

  logic [N_REQ-1:0] pick_oh;
  logic [PW-1:0]    pick_idx;
  logic [N_REQ-1:0] ready_c;
  logic [PW-1:0]    acc_idx;
  logic             done;
  logic             rel;

  rr_picker #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .valid_i  (i_req_valid),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    rr_ptr_d      = rr_ptr_q;
    lock_cnt_d    = lock_cnt_q;
    timer_d       = timer_q;
    cmd_d         = cmd_q;
    rsp_valid_d   = '0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_nack_d    = 1'b0;
    rsp_timeout_d = 1'b0;
    // A master strobe is only meaningful while a response is awaited.
    bus_err_d     = i_rsp_valid && (state_q != WAIT_RSP);
    ready_c       = '0;
    acc_idx       = gidx_q;
    done          = 1'b0;
    rel           = 1'b0;

    // In HOLD only the lock owner may issue; everyone else waits.
    case (state_q)
      IDLE: begin
        ready_c = pick_oh;
        acc_idx = pick_idx;
      end
      HOLD:    ready_c = grant_q & i_req_valid;
      default: ;
    endcase

    if (|ready_c) begin
      cmd_d.rw      = i_req_rw[acc_idx];
      cmd_d.addr    = i_req_addr[7*int'(acc_idx) +: 7];
      cmd_d.reg_ofs = i_req_reg[8*int'(acc_idx) +: 8];
      cmd_d.wdata   = i_req_wdata[8*int'(acc_idx) +: 8];
      grant_d       = ready_c;
      gidx_d        = acc_idx;
      state_d       = ISSUE;
    end

    case (state_q)
      ISSUE: begin
        if (i_cmd_ready) begin
          state_d = WAIT_RSP;
          timer_d = '0;
        end
      end
      WAIT_RSP: begin
        timer_d = timer_q + 1'b1;
        // A real response takes precedence over a coincident timeout.
        if (i_rsp_valid) begin
          rsp_valid_d = grant_q;
          rsp_rdata_d = i_rsp_rdata;
          rsp_nack_d  = i_rsp_nack;
          done        = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
          rsp_valid_d   = grant_q;
          rsp_nack_d    = 1'b1;
          rsp_timeout_d = 1'b1;
          bus_err_d     = 1'b1;
          done          = 1'b1;
        end
        if (done) begin
          if (i_req_lock[gidx_q] && (lock_cnt_q < LOCK_LAST)) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
            state_d    = HOLD;
          end else begin
            rel = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!(|ready_c) && !i_req_lock[gidx_q]) rel = 1'b1;
      end
      default: ;
    endcase

    // Release hands priority to the requester after the one just served.
    if (rel) begin
      lock_cnt_d = '0;
      rr_ptr_d   = (gidx_q == IDX_LAST) ? '0 : gidx_q + 1'b1;
      grant_d    = '0;
      state_d    = IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      gidx_q        <= '0;
      rr_ptr_q      <= '0;
      lock_cnt_q    <= '0;
      timer_q       <= '0;
      cmd_q         <= '0;
      rsp_valid_q   <= '0;
      rsp_rdata_q   <= '0;
      rsp_nack_q    <= 1'b0;
      rsp_timeout_q <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      gidx_q        <= gidx_d;
      rr_ptr_q      <= rr_ptr_d;
      lock_cnt_q    <= lock_cnt_d;
      timer_q       <= timer_d;
      cmd_q         <= cmd_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_nack_q    <= rsp_nack_d;
      rsp_timeout_q <= rsp_timeout_d;
      bus_err_q     <= bus_err_d;
    end
  end

  // Ready is combinational; gate it so every output reads 0 while in reset.
  assign o_req_ready   = ready_c & {N_REQ{i_rst_n}};
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_rdata   = rsp_rdata_q;
  assign o_rsp_nack    = rsp_nack_q;
  assign o_rsp_timeout = rsp_timeout_q;
  assign o_cmd_valid   = (state_q == ISSUE);
  assign o_cmd_rw      = cmd_q.rw;
  assign o_cmd_addr    = cmd_q.addr;
  assign o_cmd_reg     = cmd_q.reg_ofs;
  assign o_cmd_wdata   = cmd_q.wdata;
  assign o_grant       = grant_q;
  assign o_bus_error   = bus_err_q;

endmodule

// File: tb/tb_spd_i2c_arbiter.sv
// Bench for spd_i2c_arbiter: I2C master BFM with configurable ready/response
// delay, requester driver, scoreboard of accepted commands vs responses.
module tb_spd_i2c_arbiter;
  import spd_i2c_pkg::*;

  localparam int N  = 2;
  localparam int TO = 50;
  localparam int LM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid, req_lock, req_rw, req_ready;
  logic [7*N-1:0] req_addr;
  logic [8*N-1:0] req_reg, req_wdata;
  logic [N-1:0]   rsp_valid, grant;
  logic [7:0]     rsp_rdata, cmd_reg, cmd_wdata, bfm_rdata;
  logic [6:0]     cmd_addr;
  logic           rsp_nack, rsp_timeout, cmd_valid, cmd_rw, bus_error;
  logic           cmd_ready, bfm_rv, bfm_nack, stray;
  logic           rsp_valid_in;
  assign rsp_valid_in = bfm_rv | stray;

  spd_i2c_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO), .LOCK_MAX(LM)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_lock(req_lock),
    .i_req_rw(req_rw), .i_req_addr(req_addr), .i_req_reg(req_reg), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_nack(rsp_nack),
    .o_rsp_timeout(rsp_timeout), .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready),
    .o_cmd_rw(cmd_rw), .o_cmd_addr(cmd_addr), .o_cmd_reg(cmd_reg), .o_cmd_wdata(cmd_wdata),
    .i_rsp_valid(rsp_valid_in), .i_rsp_rdata(bfm_rdata), .i_rsp_nack(bfm_nack),
    .o_grant(grant), .o_bus_error(bus_error)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // BFM configuration and timing
  int   cfg_rdy_dly = 0, cfg_rsp_dly = 0;
  logic cfg_silent = 1'b0, cfg_nack = 1'b0, exp_to = 1'b0;
  int   cyc = 0, hs_cyc = 0, rsp_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // I2C master model; it keeps its pending response across reset on purpose
  // so a late strobe reaches the arbiter after reset is released.
  initial begin
    int phase, cnt;
    logic [7:0] creg;
    phase = 0; cnt = 0; creg = '0;
    cmd_ready = 1'b0; bfm_rv = 1'b0; bfm_rdata = '0; bfm_nack = 1'b0;
    forever begin
      @(posedge clk); #1;
      cmd_ready = 1'b0;
      bfm_rv    = 1'b0;
      case (phase)
        0: if (cmd_valid) begin
          creg = cmd_reg;
          if (cfg_rdy_dly == 0) begin cmd_ready = 1'b1; phase = 1; end
          else begin cnt = cfg_rdy_dly; phase = 2; end
        end
        2: begin
          cnt--;
          if (cnt == 0) begin cmd_ready = 1'b1; phase = 1; end
        end
        1: begin
          hs_cyc = cyc;
          if (cfg_silent) phase = 0;
          else if (cfg_rsp_dly == 0) begin
            bfm_rv = 1'b1; bfm_rdata = creg ^ 8'h09; bfm_nack = cfg_nack; phase = 0;
          end else begin cnt = cfg_rsp_dly; phase = 3; end
        end
        3: begin
          cnt--;
          if (cnt == 0) begin
            bfm_rv = 1'b1; bfm_rdata = creg ^ 8'h09; bfm_nack = cfg_nack; phase = 0;
          end
        end
        default: phase = 0;
      endcase
    end
  end

  // Monitor / scoreboard
  typedef struct { int r; logic [7:0] rg; logic rw; logic [7:0] wd; } exp_t;
  exp_t sb[$];
  int   acc_log[$];
  int   acc_cnt[N];
  int   rsp_cnt[N];
  int   rsp_seen = 0, bus_err_cnt = 0;

  initial for (int r = 0; r < N; r++) begin acc_cnt[r] = 0; rsp_cnt[r] = 0; end

  always @(negedge clk) begin
    if (!rst_n) sb.delete();
    else begin
      if (cmd_valid && cmd_ready) begin
        chk("cmd_inflight", sb.size(), 1);
        if (sb.size() > 0) begin
          chk("cmd_addr", cmd_addr, SPD_SLAVE_ADDR);
          chk("cmd_reg", cmd_reg, sb[0].rg);
          chk("cmd_rw", cmd_rw, sb[0].rw);
          chk("cmd_wdata", cmd_wdata, sb[0].wd);
        end
      end
      if (|rsp_valid) begin
        exp_t e;
        rsp_seen++;
        rsp_cyc = cyc;
        chk("rsp_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rsp_onehot", rsp_valid, 32'(1 << e.r));
          chk("rsp_nack", rsp_nack, cfg_nack | exp_to);
          chk("rsp_timeout", rsp_timeout, exp_to);
          if (e.rw && !(cfg_nack | exp_to)) chk("rsp_rdata", rsp_rdata, e.rg ^ 8'h09);
          rsp_cnt[e.r]++;
        end
      end
      if (bus_error) bus_err_cnt++;
      for (int r = 0; r < N; r++)
        if (req_ready[r] && req_valid[r]) begin
          acc_log.push_back(r);
          sb.push_back('{r, req_reg[8*r +: 8], req_rw[r], req_wdata[8*r +: 8]});
          acc_cnt[r]++;
        end
    end
  end

  // Requester driver
  int want[N], base_acc[N], base_rsp[N];
  logic [N-1:0] lkf;

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      req_valid[r] = (acc_cnt[r] - base_acc[r]) < want[r];
      req_lock[r]  = lkf[r] && ((rsp_cnt[r] - base_rsp[r]) < want[r]);
      req_rw[r]    = (r == 0);
      req_addr[7*r +: 7]  = SPD_SLAVE_ADDR;
      req_reg[8*r +: 8]   = 8'(32'h02 + 32 * r + acc_cnt[r]);
      req_wdata[8*r +: 8] = 8'(32'hA0 + 16 * r + acc_cnt[r]);
    end
  endtask

  task automatic run(input int n0, input int n1, input logic l0, input logic l1, input int budget);
    int k;
    k = 0;
    acc_log.delete();
    for (int r = 0; r < N; r++) begin base_acc[r] = acc_cnt[r]; base_rsp[r] = rsp_cnt[r]; end
    want[0] = n0; want[1] = n1; lkf = {l1, l0};
    drive();
    while (k < budget && !((rsp_cnt[0] - base_rsp[0] >= n0) && (rsp_cnt[1] - base_rsp[1] >= n1))) begin
      @(posedge clk); #1; drive(); k++;
    end
    chk("run_budget", k < budget, 1);
    repeat (3) begin @(posedge clk); #1; drive(); end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_cmdv"}, cmd_valid, 0);
    chk({tag, "_rspv"}, rsp_valid, 0);
    chk({tag, "_nack"}, rsp_nack, 0);
    chk({tag, "_to"}, rsp_timeout, 0);
    chk({tag, "_rdata"}, rsp_rdata, 0);
    chk({tag, "_buserr"}, bus_error, 0);
    chk({tag, "_cmdreg"}, cmd_reg, 0);
  endtask

  typedef struct {
    int n0, n1; logic l0, l1; int rdly, sdly; logic nack; int len; logic [15:0] order;
  } vec_t;
  vec_t tbl[5];

  initial begin
    int b, s, k, h0;
    // order bit i = requester of the i-th accepted transaction
    tbl[0] = '{1, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1, 16'h0000}; // single read reg 0x02 -> 0x0B
    tbl[1] = '{4, 4, 1'b0, 1'b0, 2, 3, 1'b0, 8, 16'h0055}; // contention: 1,0,1,0,...
    tbl[2] = '{1, 3, 1'b0, 1'b1, 0, 1, 1'b0, 4, 16'h0007}; // lock 3x then release in HOLD
    tbl[3] = '{1, 5, 1'b0, 1'b1, 1, 0, 1'b0, 6, 16'h002F}; // forced release after LOCK_MAX
    tbl[4] = '{1, 0, 1'b0, 1'b0, 0, 2, 1'b1, 1, 16'h0000}; // slave NACK

    stray = 1'b0;
    for (int r = 0; r < N; r++) begin want[r] = 0; base_acc[r] = 0; base_rsp[r] = 0; end
    lkf = '0;
    drive();
    req_valid = '1;
    #12 chk_zero("reset");
    req_valid = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      cfg_rdy_dly = tbl[i].rdly; cfg_rsp_dly = tbl[i].sdly; cfg_nack = tbl[i].nack;
      b = bus_err_cnt;
      run(tbl[i].n0, tbl[i].n1, tbl[i].l0, tbl[i].l1, 400);
      chk($sformatf("v%0d_len", i), acc_log.size(), tbl[i].len);
      for (int j = 0; j < tbl[i].len && j < acc_log.size(); j++)
        chk($sformatf("v%0d_order%0d", i, j), acc_log[j], {31'b0, tbl[i].order[j]});
      chk($sformatf("v%0d_buserr", i), bus_err_cnt - b, 0);
    end
    cfg_nack = 1'b0; cfg_rdy_dly = 0; cfg_rsp_dly = 0;

    // timeout with silent slave, then a normal transaction
    cfg_silent = 1'b1; exp_to = 1'b1; b = bus_err_cnt;
    run(1, 0, 1'b0, 1'b0, 200);
    chk("to_latency", rsp_cyc - hs_cyc, TO);
    chk("to_buserr", bus_err_cnt - b, 1);
    cfg_silent = 1'b0; exp_to = 1'b0; s = rsp_seen;
    run(1, 0, 1'b0, 1'b0, 100);
    chk("after_to_served", rsp_seen - s, 1);

    // response lands on the timeout cycle: normal response wins
    cfg_rsp_dly = TO - 1; b = bus_err_cnt;
    run(1, 0, 1'b0, 1'b0, 200);
    chk("coinc_latency", rsp_cyc - hs_cyc, TO);
    chk("coinc_buserr", bus_err_cnt - b, 0);
    cfg_rsp_dly = 0;

    // stray master strobe in IDLE
    b = bus_err_cnt; s = rsp_seen;
    stray = 1'b1; @(posedge clk); #1 stray = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("stray_buserr", bus_err_cnt - b, 1);
    chk("stray_norsp", rsp_seen - s, 0);

    // reset during WAIT_RSP of req0 (rr_ptr is 1 beforehand)
    cfg_rsp_dly = 10; h0 = hs_cyc; k = 0;
    acc_log.delete();
    for (int r = 0; r < N; r++) begin base_acc[r] = acc_cnt[r]; base_rsp[r] = rsp_cnt[r]; end
    want[0] = 1; want[1] = 0; lkf = '0;
    drive();
    while (hs_cyc == h0 && k < 50) begin @(posedge clk); #1; drive(); k++; end
    chk("rst_hs_seen", k < 50, 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    req_valid = '1;
    #1 chk_zero("midrst");
    req_valid = '0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    b = bus_err_cnt; s = rsp_seen;
    repeat (12) @(posedge clk);
    #1;
    chk("late_rsp_buserr", bus_err_cnt - b, 1);
    chk("late_rsp_dropped", rsp_seen - s, 0);
    cfg_rsp_dly = 0;
    run(1, 1, 1'b0, 1'b0, 200);
    chk("postrst_len", acc_log.size(), 2);
    if (acc_log.size() > 0) chk("postrst_first", acc_log[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
